// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Queues ALU requests in a small FIFO, issues them one at a time to an
// external combinational ALU through registered operand/control outputs, and
// captures each ALU result into a held response that the consumer takes with
// a valid/ready handshake. Opcodes the ALU does not implement are not sent to
// it. They produce an immediate "illegal" response instead.
//
// Parameters
//   DEPTH        request FIFO depth in entries (power of two, >= 2)
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous active-high reset
//   req_valid    request present
//   req_ready    FIFO has room (from registered count only)
//   req_a/req_b  32-bit operands
//   req_op       4-bit ALU control code
//   scrA/scrB    registered operands driven to the ALU
//   alucontrol   registered control code driven to the ALU
//   aluresult    ALU result, combinational from scrA/scrB/alucontrol
//   zero         ALU zero flag
//   rsp_valid    response held for the consumer
//   rsp_ready    consumer accepts the response
//   rsp_result   captured result
//   rsp_zero     captured zero flag
//   rsp_divzero  divide with a zero divisor
//   rsp_illegal  opcode was not a supported ALU operation
//   busy         an operation is in flight or requests are queued
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_op,
    output logic [31:0] scrA,
    output logic [31:0] scrB,
    output logic [3:0]  alucontrol,
    input  logic [31:0] aluresult,
    input  logic        zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_divzero,
    output logic        rsp_illegal,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = 32 + 32 + 4;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_DIV = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // True for the opcodes the external ALU implements.
    function automatic logic is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_DIV: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic            fifo_nonempty;
    logic [EW-1:0]   head;
    logic [31:0]     head_a;
    logic [31:0]     head_b;
    logic [3:0]      head_op;

    // Ready depends only on the registered count, so a full FIFO stays
    // not-ready even in the cycle it pops.
    assign req_ready     = (count < CW'(DEPTH));
    assign fifo_nonempty = (count != {CW{1'b0}});
    assign push          = req_valid && req_ready;

    assign head    = mem[rd_ptr];
    assign head_a  = head[EW-1 -: 32];
    assign head_b  = head[EW-33 -: 32];
    assign head_op = head[3:0];

    assign busy = (state != ST_IDLE) || fifo_nonempty;

    // Pop the FIFO head whenever the issue FSM is free to take a new entry.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: begin
                pop = fifo_nonempty;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    pop = fifo_nonempty;
                end else begin
                    pop = 1'b0;
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // FIFO storage: no reset needed, entries are only read once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_a, req_b, req_op};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            count  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM: drives the ALU inputs and captures the held response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            scrA        <= 32'd0;
            scrB        <= 32'd0;
            alucontrol  <= 4'b0000;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_zero    <= 1'b0;
            rsp_divzero <= 1'b0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (pop) begin
                        if (is_legal(head_op)) begin
                            // Legal: load the ALU and spend one cycle driving it.
                            scrA       <= head_a;
                            scrB       <= head_b;
                            alucontrol <= head_op;
                            rsp_valid  <= 1'b0;
                            state      <= ST_DRIVE;
                        end else begin
                            // Illegal: answer directly, ALU inputs untouched.
                            rsp_result  <= 32'd0;
                            rsp_zero    <= 1'b0;
                            rsp_divzero <= 1'b0;
                            rsp_illegal <= 1'b1;
                            rsp_valid   <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end else if ((state == ST_RESP) && rsp_ready) begin
                        // Response taken and nothing queued.
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        // Idle with nothing queued, or holding an unaccepted response.
                        state <= state;
                    end
                end
                ST_DRIVE: begin
                    rsp_result  <= aluresult;
                    rsp_zero    <= zero;
                    rsp_divzero <= (alucontrol == OP_DIV) && (scrB == 32'd0);
                    rsp_illegal <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= ST_RESP;
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue: directed self-checking bench for alu_issue. A small ALU model
// closes the loop from scrA/scrB/alucontrol back to aluresult/zero.
// -----------------------------------------------------------------------------
module tb_alu_issue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_op;
    logic [31:0] scrA;
    logic [31:0] scrB;
    logic [3:0]  alucontrol;
    logic [31:0] aluresult;
    logic        zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_divzero;
    logic        rsp_illegal;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_issue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .scrA        (scrA),
        .scrB        (scrB),
        .alucontrol  (alucontrol),
        .aluresult   (aluresult),
        .zero        (zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_divzero (rsp_divzero),
        .rsp_illegal (rsp_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // External ALU model.
    always_comb begin
        case (alucontrol)
            4'b0000: aluresult = scrA & scrB;
            4'b0001: aluresult = scrA | scrB;
            4'b0010: aluresult = scrA + scrB;
            4'b0110: aluresult = scrA - scrB;
            4'b0111: aluresult = ($signed(scrA) < $signed(scrB)) ? 32'd1 : 32'd0;
            4'b1010: aluresult = (scrB == 32'd0) ? 32'hFFFF_FFFF : scrA / scrB;
            default: aluresult = 32'd0;
        endcase
        zero = (aluresult == 32'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n = 0;
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("push_ready", {31'd0, req_ready}, 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    // Push one request with rsp_ready high and check latency and response.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input int exp_lat, input logic [31:0] exp_res,
                           input logic exp_zero, input logic exp_dz, input logic exp_ill,
                           input logic chk_res);
        int lat = 0;
        push(a, b, op);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        if (chk_res) check({tag, "_res"}, rsp_result, exp_res);
        check({tag, "_zero"}, {31'd0, rsp_zero}, {31'd0, exp_zero});
        check({tag, "_divzero"}, {31'd0, rsp_divzero}, {31'd0, exp_dz});
        check({tag, "_illegal"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        logic [31:0] got_res[$];
        int          got_t[$];
        logic [31:0] exp_bp[5];
        int          seen;

        reset = 1'b1; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0;
        req_op = 4'b0000; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_scrA", scrA, 32'd0);
        check("rst_alucontrol", {28'd0, alucontrol}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);

        rsp_ready = 1'b1;
        run_one("add", 32'd10, 32'd20, 4'b0010, 2, 32'd30, 1'b0, 1'b0, 1'b0, 1'b1);
        check("add_scrA", scrA, 32'd10);
        run_one("sub", 32'd30, 32'd30, 4'b0110, 2, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_one("slt", 32'd5, 32'd10, 4'b0111, 2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_one("div0", 32'd100, 32'd0, 4'b1010, 2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_one("div", 32'd100, 32'd25, 4'b1010, 2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        run_one("ill", 32'd7, 32'd9, 4'b1111, 1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ill_scrA", scrA, 32'd100);
        check("ill_scrB", scrB, 32'd25);
        check("ill_alucontrol", {28'd0, alucontrol}, 32'd10);
        @(posedge clk); #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Backpressure: DEPTH+1 requests, one held in RESP and DEPTH queued.
        rsp_ready = 1'b0;
        push(32'd10, 32'd5, 4'b0000);
        push(32'd10, 32'd5, 4'b0001);
        push(32'd10, 32'd20, 4'b0010);
        push(32'd30, 32'd15, 4'b0110);
        push(32'd5, 32'd10, 4'b0111);
        repeat (3) @(posedge clk);
        #1;
        check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_hold_result", rsp_result, 32'd0);
        check("bp_busy", {31'd0, busy}, 32'd1);
        exp_bp[0] = 32'd0; exp_bp[1] = 32'd15; exp_bp[2] = 32'd30;
        exp_bp[3] = 32'd15; exp_bp[4] = 32'd1;
        rsp_ready = 1'b1;
        for (int t = 0; t < 40 && got_res.size() < 5; t++) begin
            if (rsp_valid) begin
                got_res.push_back(rsp_result);
                got_t.push_back(t);
            end
            @(posedge clk); #1;
        end
        check("bp_count", got_res.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rsp%0d", i), (i < got_res.size()) ? got_res[i] : 32'hDEAD_BEEF, exp_bp[i]);
        end
        if (got_t.size() == 5) begin
            check("bp_spacing", got_t[4] - got_t[0], 32'd8);
        end else begin
            check("bp_spacing_len", got_t.size(), 32'd5);
        end

        // Reset while DRIVE with two entries still queued.
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        push(32'd1, 32'd2, 4'b0010);
        push(32'd3, 32'd4, 4'b0010);
        push(32'd5, 32'd6, 4'b0010);
        push(32'd7, 32'd8, 4'b0010);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("pre_rst_scrA", scrA, 32'd3);
        check("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_scrA", scrA, 32'd0);
        check("mid_rst_scrB", scrB, 32'd0);
        check("mid_rst_alucontrol", {28'd0, alucontrol}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_rsp_result", rsp_result, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("post_rst_no_rsp", seen, 32'd0);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  FIFO can accept a request.
REQ-006 req_a, req_b  input  32 each  operands.
REQ-007 req_op  input  4  ALU control code.
REQ-008 scrA, scrB  output  32 each  registered operands driven to the ALU.
REQ-009 alucontrol  output  4  registered control code driven to the ALU.
REQ-010 aluresult  input  32  ALU result, combinational from scrA/scrB/alucontrol.
REQ-011 zero  input  1  ALU zero flag.
REQ-012 rsp_valid  output  1  response held for consumer.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_result  output  32; rsp_zero  output  1; rsp_divzero  output  1; rsp_illegal  output  1  captured response fields.
REQ-015 busy  output  1  high when state is not IDLE or FIFO is non-empty.

Function
REQ-016 Request accepted on an edge where req_valid && req_ready; {req_a, req_b, req_op} written to FIFO tail.
REQ-017 req_ready SHALL equal (count < DEPTH) from registered count; no same-cycle bypass, so a full FIFO reports req_ready=0 even in a cycle where it pops.
REQ-018 Simultaneous push and pop on non-full FIFO: count unchanged, both pointers advance, pointers wrap modulo DEPTH.
REQ-019 Legal opcodes: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1010 div; all others illegal.
REQ-020 FSM states IDLE, DRIVE, RESP.
REQ-021 IDLE: FIFO non-empty -> pop head; legal op loads scrA/scrB/alucontrol, goes DRIVE; illegal op leaves ALU outputs unchanged, loads rsp_result=0, rsp_zero=0, rsp_divzero=0, rsp_illegal=1, goes RESP.
REQ-022 DRIVE: exactly one cycle; at its closing edge capture rsp_result=aluresult, rsp_zero=zero, rsp_divzero=(alucontrol==1010 && scrB==0), rsp_illegal=0; go RESP.
REQ-023 RESP: rsp_valid=1; all rsp_* fields stable until handshake.
REQ-024 RESP with rsp_ready=1: if FIFO non-empty pop next entry and go DRIVE (legal) or stay RESP with new illegal response; else go IDLE.
REQ-025 RESP with rsp_ready=0: hold state and fields; FIFO continues accepting requests.
REQ-026 Latency from accept edge (empty FIFO, IDLE) to rsp_valid high: 2 cycles for legal op, 1 cycle for illegal op.
REQ-027 Back-to-back throughput with rsp_ready held high: one legal response per 2 cycles.
REQ-028 scrA/scrB/alucontrol hold last issued values between operations.
REQ-029 Responses emerge in request order; none dropped or duplicated.

Reset
REQ-030 reset=1 asynchronously forces state IDLE, FIFO count and pointers 0, scrA=0, scrB=0, alucontrol=0000, all rsp_* fields 0, rsp_valid=0, busy=0.
REQ-031 req_ready SHALL be 1 while reset is low and FIFO empty; reset asserted mid-operation discards in-flight and queued requests with no response emitted.

Verification
REQ-032 Add: a=10, b=20, op=0010, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_result=30, rsp_zero=0, flags 0.
REQ-033 Sub/zero: a=30, b=30, op=0110 -> rsp_result=0, rsp_zero=1; then slt a=5, b=10 -> rsp_result=1.
REQ-034 Div by zero: a=100, b=0, op=1010 -> rsp_divzero=1; div a=100, b=25 -> rsp_result=4, rsp_divzero=0.
REQ-035 Backpressure: rsp_ready=0, push DEPTH+1 requests (and, or, add, sub, slt) -> req_ready=0 after FIFO fills with one held in RESP; release rsp_ready -> 5 responses in order (0, 15, 30, 15, 1 for a=10/b=5 and/or, 10+20, 30-15, 5<10).
REQ-036 Illegal op 1111 -> rsp_illegal=1, rsp_result=0 one cycle after accept; scrA/scrB/alucontrol unchanged.
REQ-037 Reset asserted while in DRIVE with 2 queued -> all outputs zero immediately, busy=0, no response after reset release.
